bilinear_wr_coalescer: RTL
==========================

// Module: bilinear_wr_coalescer
// PURPOSE
//  Sits directly downstream of the bilinear downscale top. Consumes its N-lane byte write stream
//  (wr_valid/wr_addr/wr_data) and packs the bytes into 32-bit word writes with byte enables.
//  Words are buffered in a multi-push FIFO and drained through a valid/ready port to memory.
//  The core cannot stall, so any FIFO shortfall drops words and sets a sticky overflow flag.
// PARAMETERS
//  N        4   byte lanes per cycle (matches the core's SIMD width)
//  DEPTH    8   FIFO entries (power of 2, >= N)
//  TIMEOUT  16  idle cycles before auto-flush; used only with BILINEAR_WRC_TIMEOUT_EN
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   N       per-lane byte write strobe
//  in_addr    in   N*32    per-lane byte address; lane k at [k*32+:32]
//  in_data    in   N*8     per-lane byte data
//  flush      in   1       pulse: close the open word
//  mem_valid  out  1       FIFO head valid
//  mem_ready  in   1       memory accepts the head
//  mem_addr   out  32      word address; [1:0] is always 0
//  mem_data   out  32      packed data; byte b at [b*8+:8]
//  mem_be     out  4       byte enables
//  empty      out  1       FIFO empty and no open word
//  overflow   out  1       sticky: a word was dropped
//  words_out  out  32      popped-word count; wraps at 2^32
// BEHAVIOUR
//  Reset: all outputs 0 except empty=1; open word invalid; FIFO pointers and count 0.
//  Open word register holds {tag = addr[31:2], data[31:0], be[3:0], vld}.
//  Each cycle, lanes 0..N-1 are scanned in order; invalid lanes are skipped.
//   - vld && tag match: merge byte at addr[1:0] and set that be bit.
//     A byte written twice keeps the higher lane's data.
//   - No match (or !vld): close the current word (push if vld), then open a new word with this byte only.
//  After the lane scan, if flush=1 and a word is open, it is closed (pushed) and vld is cleared.
//  Pushes happen in lane order, then the flush push. Up to N+1 pushes per cycle into consecutive slots.
//  Free slots per cycle = DEPTH - count + (pop this cycle).
//   - Pushes beyond free are discarded (the latest ones) and overflow is set.
//   - overflow clears only on rst.
//  Output: mem_valid = (count != 0). Head addr/data/be are driven from the registered FIFO.
//   - Pop when mem_valid && mem_ready; words_out increments on each pop.
//   - Head is stable while mem_valid && !mem_ready.
//  Latency: a word closed in cycle t (push at edge t) gives mem_valid=1 in cycle t+1 if the FIFO was empty.
//  The open word never reaches memory without a later closing event (new tag, flush, or timeout).
//  Reset mid-operation discards the open word and all FIFO contents; mem_valid=0 in the cycle after rst.
//  Push and pop in the same cycle at full: one slot is freed and reused; no overflow for a single push.
// CONFIGURATION
//  BILINEAR_WRC_TIMEOUT_EN defined:
//   - An idle counter resets on any in_valid bit or flush, and increments while a word is open.
//   - At TIMEOUT it behaves as flush: it closes the word and resets the counter.
//  Not defined: no counter; the open word is closed only by tag change or flush. TIMEOUT is ignored.
// TESTING
//  1. mem_ready=1; lanes addr 0x100..0x103, data 11,22,33,44 in one cycle; flush next cycle
//     -> one word: addr 0x100, data 0x44332211, be 0xF, words_out=1.
//  2. Lanes 0x102,0x103,0x104,0x105, data A0..A3; then flush
//     -> word 0x100 be 0xC data 0xA1A00000; word 0x104 be 0x3 data 0x0000A3A2.
//  3. Lanes 0,1 both addr 0x200, data AA/BB; flush -> addr 0x200, be 0x1, data[7:0]=BB.
//  4. mem_ready=0, DEPTH=8; push 9 words (distinct tags)
//     -> overflow=1; after mem_ready=1 exactly 8 words drain in order; the 9th is absent.
//  5. FIFO holding 3 words plus an open word; assert rst one cycle
//     -> next cycle mem_valid=0, empty=1, overflow=0, words_out=0; no stale words ever appear.
//  6. With BILINEAR_WRC_TIMEOUT_EN, TIMEOUT=16: single byte 0x300, then idle
//     -> word 0x300 pushed after 16 idle cycles. Without the macro: no push until flush.

Source files
------------

// File: rtl/bilinear_wr_coalescer.sv
// ---------------------------------------------------------------------------
// bilinear_wr_coalescer
//   Packs the N-lane byte write stream of the bilinear downscale core into
//   32-bit word writes with byte enables. Bytes merge into one open word while
//   they share a word address (tag). Closed words go into a multi-push FIFO
//   that drains through a valid/ready port. The core cannot be stalled, so
//   words that do not fit are dropped and a sticky overflow flag is raised.
//
// Optional feature macro: BILINEAR_WRC_TIMEOUT_EN
//   When defined, an idle counter closes the open word after TIMEOUT idle
//   cycles. When undefined, the open word closes only on tag change or flush.
//
// Ports
//   clk        in   1      clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   N      per-lane byte write strobe
//   in_addr    in   N*32   per-lane byte address, lane k at [k*32+:32]
//   in_data    in   N*8    per-lane byte data, lane k at [k*8+:8]
//   flush      in   1      close the open word
//   mem_valid  out  1      FIFO head valid
//   mem_ready  in   1      memory accepts the head
//   mem_addr   out  32     word address, [1:0] always 0
//   mem_data   out  32     packed data, byte b at [b*8+:8]
//   mem_be     out  4      byte enables
//   empty      out  1      FIFO empty and no open word
//   overflow   out  1      sticky, a word was dropped
//   words_out  out  32     popped-word count (wraps)
// ---------------------------------------------------------------------------
module bilinear_wr_coalescer #(
  parameter int N       = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*32-1:0] in_addr,
  input  logic [N*8-1:0]  in_data,
  input  logic            flush,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_data,
  output logic [3:0]      mem_be,
  output logic            empty,
  output logic            overflow,
  output logic [31:0]     words_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NP = N + 1;               // lane closes plus one flush close
  localparam int PW = $clog2(NP + 1);

  if ((DEPTH < N) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
    $error("bilinear_wr_coalescer: DEPTH must be a power of 2 >= N and TIMEOUT >= 1");
  end

  // Open word
  logic [29:0]   r_tag;
  logic [31:0]   r_data;
  logic [3:0]    r_be;
  logic          r_vld;

  // FIFO storage (tag kept, address low bits are always zero)
  logic [29:0]   r_fifo_tag  [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [3:0]    r_fifo_be   [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [31:0]   r_words_out;

  // Combinational scan results
  logic [29:0]   w_push_tag  [NP];
  logic [31:0]   w_push_data [NP];
  logic [3:0]    w_push_be   [NP];
  logic [PW-1:0] w_push_cnt;
  logic [29:0]   w_nxt_tag;
  logic [31:0]   w_nxt_data;
  logic [3:0]    w_nxt_be;
  logic          w_nxt_vld;
  logic [31:0]   w_lane_addr;
  logic [7:0]    w_lane_byte;
  logic          w_flush;
  logic          w_timeout;
  logic          w_pop;
  logic [CW-1:0] w_free;
  logic [CW-1:0] w_acc_cnt;
  logic          w_drop;

`ifdef BILINEAR_WRC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_idle;

  assign w_timeout = (r_idle == TW'(TIMEOUT));

  // Idle counter: restarts on any activity, counts while a word is open
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= '0;
    end else if ((|in_valid) || flush || w_timeout) begin
      r_idle <= '0;
    end else if (r_vld) begin
      r_idle <= r_idle + TW'(1);
    end else begin
      r_idle <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_flush = flush | w_timeout;

  // Lane scan: merge or close/open per lane, then the flush close
  always_comb begin
    w_nxt_tag   = r_tag;
    w_nxt_data  = r_data;
    w_nxt_be    = r_be;
    w_nxt_vld   = r_vld;
    w_push_cnt  = '0;
    w_lane_addr = 32'd0;
    w_lane_byte = 8'd0;
    for (int p = 0; p < NP; p++) begin
      w_push_tag[p]  = 30'd0;
      w_push_data[p] = 32'd0;
      w_push_be[p]   = 4'd0;
    end
    for (int k = 0; k < N; k++) begin
      w_lane_addr = in_addr[k*32 +: 32];
      w_lane_byte = in_data[k*8 +: 8];
      if (in_valid[k] && w_nxt_vld && (w_nxt_tag == w_lane_addr[31:2])) begin
        w_nxt_data[{w_lane_addr[1:0], 3'b000} +: 8] = w_lane_byte;
        w_nxt_be[w_lane_addr[1:0]] = 1'b1;
      end else if (in_valid[k]) begin
        // The slot is always written; it only counts when a word was open.
        w_push_tag[w_push_cnt]  = w_nxt_tag;
        w_push_data[w_push_cnt] = w_nxt_data;
        w_push_be[w_push_cnt]   = w_nxt_be;
        w_push_cnt = w_push_cnt + PW'(w_nxt_vld);
        w_nxt_tag  = w_lane_addr[31:2];
        w_nxt_data = 32'd0;
        w_nxt_data[{w_lane_addr[1:0], 3'b000} +: 8] = w_lane_byte;
        w_nxt_be   = 4'd0;
        w_nxt_be[w_lane_addr[1:0]] = 1'b1;
        w_nxt_vld  = 1'b1;
      end else begin
        w_nxt_vld = w_nxt_vld;
      end
    end
    w_push_tag[w_push_cnt]  = w_nxt_tag;
    w_push_data[w_push_cnt] = w_nxt_data;
    w_push_be[w_push_cnt]   = w_nxt_be;
    w_push_cnt = w_push_cnt + PW'(w_flush & w_nxt_vld);
    w_nxt_vld  = w_nxt_vld & ~w_flush;
  end

  // Admission: a same-cycle pop frees one slot; the latest pushes are dropped
  always_comb begin
    w_pop  = (r_count != '0) && mem_ready;
    w_free = CW'(DEPTH) - r_count + CW'(w_pop);
    if (32'(w_push_cnt) > 32'(w_free)) begin
      w_acc_cnt = w_free;
      w_drop    = 1'b1;
    end else begin
      w_acc_cnt = CW'(w_push_cnt);
      w_drop    = 1'b0;
    end
  end

  // Open word, FIFO, overflow flag and pop counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag       <= 30'd0;
      r_data      <= 32'd0;
      r_be        <= 4'd0;
      r_vld       <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_words_out <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_tag[i]  <= 30'd0;
        r_fifo_data[i] <= 32'd0;
        r_fifo_be[i]   <= 4'd0;
      end
    end else begin
      r_tag  <= w_nxt_tag;
      r_data <= w_nxt_data;
      r_be   <= w_nxt_be;
      r_vld  <= w_nxt_vld;
      for (int p = 0; p < NP; p++) begin
        if (p < int'(w_acc_cnt)) begin
          r_fifo_tag[r_wr_ptr + AW'(p)]  <= w_push_tag[p];
          r_fifo_data[r_wr_ptr + AW'(p)] <= w_push_data[p];
          r_fifo_be[r_wr_ptr + AW'(p)]   <= w_push_be[p];
        end
      end
      r_wr_ptr    <= r_wr_ptr + AW'(w_acc_cnt);
      r_rd_ptr    <= r_rd_ptr + AW'(w_pop);
      r_count     <= r_count + w_acc_cnt - CW'(w_pop);
      r_overflow  <= r_overflow | w_drop;
      r_words_out <= r_words_out + 32'(w_pop);
    end
  end

  assign mem_valid = (r_count != '0);
  assign mem_addr  = {r_fifo_tag[r_rd_ptr], 2'b00};
  assign mem_data  = r_fifo_data[r_rd_ptr];
  assign mem_be    = r_fifo_be[r_rd_ptr];
  assign empty     = (r_count == '0) && !r_vld;
  assign overflow  = r_overflow;
  assign words_out = r_words_out;

endmodule
